uart_frame_loader: RTL
======================

Name: uart_frame_loader

Overview:
Byte-level protocol controller sitting directly behind the UART receiver. It consumes the receiver's one-cycle done strobe and data byte, parses framed packets (sync, command, start address, length, payload, checksum) and streams payload bytes into a byte-wide memory/register bank. It reports frame completion, the command byte, and framing errors to the rest of the design, and recovers from line stalls with an inter-byte timeout.

Parameters:
SYNC_BYTE, 8'hA5, start-of-frame marker
ADDR_W, 8, memory address width (1..8); the address byte is truncated to its ADDR_W LSBs
MAX_LEN, 64, largest legal payload length (1..255)
TIMEOUT_CLKS, 4000, idle clocks allowed between bytes inside a frame before abort (≥2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_done_tick  in  1  one-cycle strobe from the receiver: rx_data valid
rx_data  in  8  received byte
mem_we  out  1  payload write strobe, one cycle per payload byte
mem_addr  out  ADDR_W  payload write address
mem_wdata  out  8  payload write data
cmd  out  8  command byte of the last good frame
frame_done  out  1  one-cycle pulse: frame accepted (checksum OK)
frame_err  out  1  one-cycle pulse: frame aborted
err_code  out  2  cause of the last abort: 1 checksum, 2 length, 3 timeout; holds until the next abort
busy  out  1  high in every state except S_SYNC

Behaviour:
- Frame format: SYNC, CMD, ADDR, LEN, LEN payload bytes, CHK. CHK = XOR of CMD, ADDR, LEN and all payload bytes (SYNC excluded).
- Reset (async, any time, including mid-frame): state S_SYNC; mem_we, mem_addr, mem_wdata, cmd, frame_done, frame_err, err_code, busy = 0; running checksum, byte counter and timeout counter cleared.
- All outputs are registered. Every action happens on the clk edge where rx_done_tick=1; the result is visible the following cycle.
- S_SYNC: a byte equal to SYNC_BYTE -> S_CMD and the checksum is cleared. Any other byte is ignored silently (no error).
- S_CMD: the byte is latched internally (not yet on cmd) and seeds the checksum -> S_ADDR.
- S_ADDR: the byte is loaded into the write pointer and XORed into the checksum -> S_LEN.
- S_LEN: if LEN > MAX_LEN -> frame_err pulse, err_code=2, S_SYNC. If LEN = 0 -> S_CHK. Otherwise load the remaining count -> S_DATA. The checksum is updated in all three cases.
- S_DATA: each byte produces mem_we=1 for exactly one cycle, with mem_addr = pointer and mem_wdata = byte. The pointer then increments modulo 2^ADDR_W (wraps FF -> 00). After the LEN-th byte -> S_CHK.
- Payload is streamed, not buffered: writes made before a checksum failure or timeout are not undone.
- S_CHK: if the byte equals the running checksum -> frame_done pulse and cmd is updated with the latched command. Otherwise -> frame_err pulse, err_code=1, cmd unchanged. Either way -> S_SYNC.
- Timeout: the counter runs only while busy and clears on every rx_done_tick. When it reaches TIMEOUT_CLKS-1 with no byte -> frame_err pulse, err_code=3, S_SYNC.
- Simultaneous byte and timeout in the same cycle: the byte wins; no timeout is raised and the byte is processed normally.
- frame_done and frame_err are never asserted in the same cycle. mem_we never asserts outside S_DATA processing.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Test Plan:
- Byte stream 00 A5 01 10 03 11 22 33 12 -> leading 00 ignored; writes (10,11),(11,22),(12,33), one per byte, each one cycle after its tick; then frame_done=1 for one cycle, cmd=01, err_code=0.
- A5 07 00 00 07 -> no mem_we; frame_done pulse; cmd=07.
- A5 01 10 03 11 22 33 13 -> three writes occur; frame_err pulse, err_code=1; cmd keeps its previous value.
- A5 01 00 41 -> frame_err pulse one cycle after the LEN tick, err_code=2, no writes; a following A5 09 FF 02 AA BB xx (correct CHK) writes FF=AA and 00=BB, then frame_done with cmd=09.
- A5 01, then no tick for TIMEOUT_CLKS cycles -> frame_err, err_code=3, busy=0. A variant with a byte arriving exactly on the expiry cycle produces no error.
- Assert reset during S_DATA -> all outputs 0 immediately; after release the next valid frame is accepted normally.

Source files
------------

// File: rtl/uart_frame_loader_if.sv
// Receiver-facing byte strobe plus the loader's memory-write and status outputs.
// master: the frame loader itself; slave: the surrounding design.
interface uart_frame_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_done_tick;
  logic [7:0]        rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        cmd;
  logic              frame_done;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              busy;

  modport master (
    input  rx_done_tick, rx_data,
    output mem_we, mem_addr, mem_wdata, cmd, frame_done, frame_err, err_code, busy
  );

  modport slave (
    output rx_done_tick, rx_data,
    input  mem_we, mem_addr, mem_wdata, cmd, frame_done, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Framed-packet parser behind a UART receiver:
// SYNC, CMD, ADDR, LEN, payload[LEN], CHK (XOR of everything after SYNC).
// Payload bytes are streamed straight to memory; an inter-byte timeout
// returns the parser to hunting for SYNC when the line stalls mid-frame.
module uart_frame_loader #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         ADDR_W       = 8,
  parameter int         MAX_LEN      = 64,
  parameter int         TIMEOUT_CLKS = 4000
) (
  input logic               clk,
  input logic               reset,
  uart_frame_loader_if.master bus
);
  localparam logic [2:0] S_SYNC = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

  localparam int              TW       = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]      MAX_L    = 8'(MAX_LEN);

  logic [2:0]        state;
  logic [7:0]        cmd_lat;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        remain;
  logic [TW-1:0]     tmo;

  // Frame parser: bytes always take priority over an expiring timeout.
  // busy is kept as a register that mirrors (state != S_SYNC) so every
  // output comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_SYNC;
      cmd_lat        <= '0;
      csum           <= '0;
      ptr            <= '0;
      remain         <= '0;
      tmo            <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.cmd        <= '0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.err_code   <= '0;
      bus.busy       <= 1'b0;
    end else begin
      bus.mem_we     <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      if (bus.rx_done_tick) begin
        tmo <= '0;
        case (state)
          S_SYNC: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state    <= S_CMD;
              bus.busy <= 1'b1;
              csum     <= '0;
            end
          end
          S_CMD: begin
            cmd_lat <= bus.rx_data;
            csum    <= bus.rx_data;
            state   <= S_ADDR;
          end
          S_ADDR: begin
            ptr   <= bus.rx_data[ADDR_W-1:0];
            csum  <= csum ^ bus.rx_data;
            state <= S_LEN;
          end
          S_LEN: begin
            csum <= csum ^ bus.rx_data;
            if (bus.rx_data > MAX_L) begin
              bus.frame_err <= 1'b1;
              bus.err_code  <= 2'd2;
              state         <= S_SYNC;
              bus.busy      <= 1'b0;
            end else if (bus.rx_data == 8'd0) begin
              state <= S_CHK;
            end else begin
              remain <= bus.rx_data;
              state  <= S_DATA;
            end
          end
          S_DATA: begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ptr;
            bus.mem_wdata <= bus.rx_data;
            ptr           <= ptr + 1'b1;
            csum          <= csum ^ bus.rx_data;
            remain        <= remain - 8'd1;
            if (remain == 8'd1) state <= S_CHK;
          end
          S_CHK: begin
            if (bus.rx_data == csum) begin
              bus.frame_done <= 1'b1;
              bus.cmd        <= cmd_lat;
            end else begin
              bus.frame_err <= 1'b1;
              bus.err_code  <= 2'd1;
            end
            state    <= S_SYNC;
            bus.busy <= 1'b0;
          end
          default: begin
            state    <= S_SYNC;
            bus.busy <= 1'b0;
          end
        endcase
      end else if (bus.busy) begin
        if (tmo == TMO_LAST) begin
          bus.frame_err <= 1'b1;
          bus.err_code  <= 2'd3;
          state         <= S_SYNC;
          bus.busy      <= 1'b0;
          tmo           <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end
endmodule
